rsa_row_mac_seq: RTL and testbench
==================================

# rsa_row_mac_seq

Sequencer for the RSA word-serial multiply datapath. It drives the read addresses of the modulus/operand memory (`mem_m`) and the exponent/operand memory (`mem_e`), and tracks the synchronous-read and multiplier pipeline latency. It then folds each 64-bit partial product with a running carry, producing one multi-word row product `A[0..len-1] * B`. The result streams out least-significant word first, as `len+1` result words. This row operation is the building block for the later schoolbook/Montgomery multiply controller.

## Interface
- `WIDTH`, 32, operand word width; product width is 2*WIDTH.
- `ADDR_WIDTH`, 7, memory address width.
- `MUL_LAT`, 1, multiplier register stages (≥1); total read-to-product depth D = 1 + MUL_LAT.

- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a row operation; sampled only in IDLE.
- `len` input ADDR_WIDTH+1: number of A words, 0..2^ADDR_WIDTH.
- `m_base` input ADDR_WIDTH: first A address in `mem_m`.
- `e_addr` input ADDR_WIDTH: address of the B word in `mem_e`.
- `addr_m` output ADDR_WIDTH: registered read address to `mem_m`.
- `addr_e` output ADDR_WIDTH: registered read address to `mem_e`.
- `mul_lo` input WIDTH: multiplier low product half.
- `mul_hi` input WIDTH: multiplier high product half.
- `busy` output 1: operation in progress.
- `out_valid` output 1: `out_data`/`out_idx` valid this cycle.
- `out_data` output WIDTH: result word.
- `out_idx` output ADDR_WIDTH+1: result word index, 0..len.
- `done` output 1: one-cycle pulse coincident with the final result word.

## Operation
- FSM states:
  - IDLE: waiting for `start`.
  - ISSUE: one address per cycle for `len` cycles.
  - DRAIN: waiting for in-flight products.
  - FLUSH: one cycle emitting the carry word.
  - IDLE again.
- IDLE + `start` = 1: latch `len`, `m_base`, `e_addr`; clear carry and index; go to ISSUE (FLUSH if `len` = 0).
- ISSUE: `addr_m` = (`m_base` + i) mod 2^ADDR_WIDTH for i = 0..len-1; `addr_e` = latched `e_addr` for the whole operation. A D-deep valid shift register tags each issued read.
- Tagged product arrival: sum = {mul_hi,mul_lo} + zero-extended carry (2*WIDTH bits, cannot overflow); `out_data` = sum[WIDTH-1:0]; carry = sum[2*WIDTH-1:WIDTH]; `out_idx` increments.
- After the last issue, DRAIN waits until the valid shift register is empty, then FLUSH outputs `out_data` = carry, `out_idx` = len, `done` = 1.
- `len` = 0: no reads issued; FLUSH emits a single word 0 at index 0 with `done`.
- `start` while busy: ignored.
- Address wrap past 2^ADDR_WIDTH-1 to 0 is legal.
- No backpressure: the consumer must accept one word per cycle.

## Timing
- Reset values: `addr_m`=0, `addr_e`=0, `busy`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `done`=0, carry=0, FSM=IDLE, valid pipe cleared.
- Cycle 0: `start` sampled. Cycles 1..len: `addr_m` = m_base+i, `busy`=1.
- Product for word i is at `mul_*` in cycle 1+i+D.
- `out_valid` for word i is in cycle 2+i+D; back-to-back, no bubbles.
- Carry word plus `done`: cycle 2+len+D; `busy` falls the next cycle.
- Latency start→done = len+D+2 cycles; `len` = 0 gives `done` in cycle 1.
- Earliest next `start` is accepted in the cycle after `done`.
- `reset` mid-operation: FSM returns to IDLE at that edge and all outputs take reset values. No stale `out_valid` may appear afterward, even though products are still in the multiplier.
- `reset` and `start` in the same cycle: reset wins.

## Test plan
- MUL_LAT=1, m[5]=0xFFFFFFFF, m[6]=0xFFFFFFFF, e[2]=0xFFFFFFFF, start with len=2, m_base=5, e_addr=2 -> words 0x00000001, 0xFFFFFFFF, 0xFFFFFFFE at cycles 4, 5, 6; `done` at cycle 6.
- len=3, m={1,2,3} at base 0, e=0x10 -> `addr_m` 0,1,2 at cycles 1-3; outputs 0x10, 0x20, 0x30, 0x0 at cycles 4-7 with `out_idx` 0-3; `done` at cycle 7.
- Wrap: m_base=0x7E, len=4 -> `addr_m` sequence 0x7E, 0x7F, 0x00, 0x01; result matches the reference model.
- len=0 -> `busy` high one cycle; `out_valid`=1, `out_data`=0, `out_idx`=0, `done`=1 at cycle 1; `addr_m` unchanged.
- `start` re-pulsed during ISSUE -> ignored, result unchanged. `reset` asserted at cycle 3 of a len=8 operation -> all outputs 0 from cycle 4 onward, no `out_valid`. A new start then completes correctly.
- MUL_LAT=3, random 128-word A and random B -> 129 words match the big-integer model; `done` at cycle 128+4+2=134.

Source files
------------

// File: rtl/rsa_row_mac_seq.sv
// Row multiply sequencer: issues A[i]/B read addresses and folds each partial product with a running carry.
// Latency start->done = len+D+2 cycles (D = 1+MUL_LAT); no backpressure, one result word per cycle.
module rsa_row_mac_seq #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int MUL_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] m_base,
  input  logic [ADDR_WIDTH-1:0] e_addr,
  output logic [ADDR_WIDTH-1:0] addr_m,
  output logic [ADDR_WIDTH-1:0] addr_e,
  input  logic [WIDTH-1:0]      mul_lo,
  input  logic [WIDTH-1:0]      mul_hi,
  output logic                  busy,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH:0]   out_idx,
  output logic                  done
);

  localparam int D = 1 + MUL_LAT;
  localparam logic [ADDR_WIDTH:0]   ONE_L = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t              state, state_nx;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] widx;
  logic [WIDTH-1:0]    carry;
  logic [D-1:0]        vpipe;
  logic [2*WIDTH-1:0]  sum;
  logic                last_issue;

  // The carry is at most 2^WIDTH-1, so this sum always fits in 2*WIDTH bits.
  assign sum        = {mul_hi, mul_lo} + {{WIDTH{1'b0}}, carry};
  assign last_issue = (cnt == len_q - ONE_L);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? FLUSH : ISSUE;
      ISSUE:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (vpipe == '0) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      widx      <= '0;
      carry     <= '0;
      vpipe     <= '0;
      addr_m    <= '0;
      addr_e    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      done      <= 1'b0;
      // Tag tap D-1 lines up with the product of the read issued D cycles earlier.
      vpipe     <= {vpipe[D-2:0], state == ISSUE};
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            cnt    <= '0;
            widx   <= '0;
            carry  <= '0;
            addr_e <= e_addr;
            if (len == '0) begin
              out_valid <= 1'b1;
              out_data  <= '0;
              out_idx   <= '0;
              done      <= 1'b1;
            end else begin
              addr_m <= m_base;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + ONE_L;
          if (!last_issue) addr_m <= addr_m + ONE_A;
        end
        DRAIN: begin
          if (vpipe == '0) begin
            out_valid <= 1'b1;
            out_data  <= carry;
            out_idx   <= len_q;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
      if (vpipe[D-1]) begin
        out_valid <= 1'b1;
        out_data  <= sum[WIDTH-1:0];
        carry     <= sum[2*WIDTH-1:WIDTH];
        out_idx   <= widx;
        widx      <= widx + ONE_L;
      end
    end
  end

endmodule

// File: tb/tb_rsa_row_mac_seq.sv
// Bench for rsa_row_mac_seq: two instances (MUL_LAT=1 and 3) against memory/multiplier models and a big-integer reference.
module tb_rsa_row_mac_seq;

  localparam int BIGW = 32 * 130;
  localparam int KOFF = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntest = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  logic        reset;
  logic        start    [2];
  logic [7:0]  len_s    [2];
  logic [6:0]  base_s   [2];
  logic [6:0]  ea_s     [2];
  logic [6:0]  addr_m   [2];
  logic [6:0]  addr_e   [2];
  logic [31:0] mul_lo   [2];
  logic [31:0] mul_hi   [2];
  logic        busy     [2];
  logic        out_valid[2];
  logic [31:0] out_data [2];
  logic [7:0]  out_idx  [2];
  logic        done     [2];

  logic [31:0] mem_m [2][128];
  logic [31:0] mem_e [2][128];
  logic [31:0] m_q   [2];
  logic [31:0] e_q   [2];
  logic [63:0] pipe  [2][3];

  rsa_row_mac_seq #(.WIDTH(32), .ADDR_WIDTH(7), .MUL_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .len(len_s[0]), .m_base(base_s[0]),
    .e_addr(ea_s[0]), .addr_m(addr_m[0]), .addr_e(addr_e[0]), .mul_lo(mul_lo[0]),
    .mul_hi(mul_hi[0]), .busy(busy[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_idx(out_idx[0]), .done(done[0]));

  rsa_row_mac_seq #(.WIDTH(32), .ADDR_WIDTH(7), .MUL_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .len(len_s[1]), .m_base(base_s[1]),
    .e_addr(ea_s[1]), .addr_m(addr_m[1]), .addr_e(addr_e[1]), .mul_lo(mul_lo[1]),
    .mul_hi(mul_hi[1]), .busy(busy[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_idx(out_idx[1]), .done(done[1]));

  // Synchronous-read memories followed by a 1-stage or 3-stage multiplier.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      m_q[n]     <= mem_m[n][addr_m[n]];
      e_q[n]     <= mem_e[n][addr_e[n]];
      pipe[n][0] <= {32'b0, m_q[n]} * {32'b0, e_q[n]};
      pipe[n][1] <= pipe[n][0];
      pipe[n][2] <= pipe[n][1];
    end
  end
  assign {mul_hi[0], mul_lo[0]} = pipe[0][0];
  assign {mul_hi[1], mul_lo[1]} = pipe[1][2];

  // Expectations keyed by instance*KOFF + absolute cycle.
  logic [31:0] exp_data[int];
  logic [7:0]  exp_idx [int];
  bit          exp_done[int];
  logic [6:0]  exp_am  [int];
  logic [6:0]  exp_ae  [int];
  int bstart[2];
  int bend  [2];
  int dlat  [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  int  cmp_key;
  bit  cmp_ev;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        cmp_key = n * KOFF + cyc;
        cmp_ev  = exp_data.exists(cmp_key);
        chk($sformatf("out_valid%0d", n), 64'(out_valid[n]), 64'(cmp_ev));
        if (cmp_ev) begin
          chk($sformatf("out_data%0d", n), 64'(out_data[n]), 64'(exp_data[cmp_key]));
          chk($sformatf("out_idx%0d", n), 64'(out_idx[n]), 64'(exp_idx[cmp_key]));
          chk($sformatf("done%0d", n), 64'(done[n]), 64'(exp_done[cmp_key]));
        end else begin
          chk($sformatf("done%0d", n), 64'(done[n]), 64'(0));
        end
        chk($sformatf("busy%0d", n), 64'(busy[n]), 64'(cyc > bstart[n] && cyc <= bend[n]));
        if (exp_am.exists(cmp_key)) begin
          chk($sformatf("addr_m%0d", n), 64'(addr_m[n]), 64'(exp_am[cmp_key]));
          chk($sformatf("addr_e%0d", n), 64'(addr_e[n]), 64'(exp_ae[cmp_key]));
        end
      end
    end
  end

  // Start request in the current cycle; the model records it only if the DUT is idle and not in reset.
  task automatic issue(input int n, input int ln, input int base, input int ea);
    int c0;
    int key;
    logic [BIGW-1:0] big;
    logic [BIGW-1:0] term;
    logic [6:0] a;
    c0        = cyc;
    start[n]  = 1'b1;
    len_s[n]  = 8'(ln);
    base_s[n] = 7'(base);
    ea_s[n]   = 7'(ea);
    if (c0 > bend[n] && !reset) begin
      big = '0;
      for (int i = 0; i < ln; i++) begin
        a          = 7'(base + i);
        term       = '0;
        term[63:0] = {32'b0, mem_m[n][a]} * {32'b0, mem_e[n][7'(ea)]};
        big        = big + (term << (32 * i));
        exp_am[n * KOFF + c0 + 1 + i] = a;
        exp_ae[n * KOFF + c0 + 1 + i] = 7'(ea);
      end
      for (int k = 0; k <= ln; k++) begin
        key = n * KOFF + ((ln == 0) ? c0 + 1 : c0 + 2 + k + dlat[n]);
        exp_data[key] = big[32 * k +: 32];
        exp_idx[key]  = 8'(k);
        exp_done[key] = (k == ln);
      end
      bstart[n] = c0;
      bend[n]   = (ln == 0) ? c0 + 1 : c0 + 2 + ln + dlat[n];
    end
    @(negedge clk);
    start[n] = 1'b0;
  endtask

  // Reset sampled at the end of cycle r: nothing is expected from r+1 on.
  task automatic purge(input int r);
    int keys[$];
    int k;
    if (exp_data.first(k)) do begin
      if (k % KOFF > r) keys.push_back(k);
    end while (exp_data.next(k));
    foreach (keys[j]) begin
      exp_data.delete(keys[j]);
      exp_idx.delete(keys[j]);
      exp_done.delete(keys[j]);
    end
    keys.delete();
    if (exp_am.first(k)) do begin
      if (k % KOFF > r) keys.push_back(k);
    end while (exp_am.next(k));
    foreach (keys[j]) begin
      exp_am.delete(keys[j]);
      exp_ae.delete(keys[j]);
    end
    for (int n = 0; n < 2; n++) if (bend[n] > r) bend[n] = r;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    purge(cyc);
    repeat (ncyc) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      start[n] = 1'b0; len_s[n] = '0; base_s[n] = '0; ea_s[n] = '0;
      bstart[n] = -1; bend[n] = -1;
      for (int i = 0; i < 128; i++) begin
        mem_m[n][i] = '0;
        mem_e[n][i] = '0;
      end
    end
    dlat[0] = 2;
    dlat[1] = 4;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    for (int n = 0; n < 2; n++) begin
      chk("rst_addr_m", 64'(addr_m[n]), 64'(0));
      chk("rst_addr_e", 64'(addr_e[n]), 64'(0));
      chk("rst_busy", 64'(busy[n]), 64'(0));
      chk("rst_out_valid", 64'(out_valid[n]), 64'(0));
      chk("rst_out_data", 64'(out_data[n]), 64'(0));
      chk("rst_out_idx", 64'(out_idx[n]), 64'(0));
      chk("rst_done", 64'(done[n]), 64'(0));
    end

    // All-ones operands: carry propagation through every word.
    mem_m[0][5] = 32'hFFFFFFFF;
    mem_m[0][6] = 32'hFFFFFFFF;
    mem_e[0][2] = 32'hFFFFFFFF;
    c0 = cyc;
    issue(0, 2, 5, 2);
    chk("t1_w0", 64'(exp_data[c0 + 4]), 64'h1);
    chk("t1_w1", 64'(exp_data[c0 + 5]), 64'hFFFFFFFF);
    chk("t1_w2", 64'(exp_data[c0 + 6]), 64'hFFFFFFFE);
    chk("t1_done", 64'(exp_done[c0 + 6]), 64'(1));
    wait_cyc(bend[0] + 1);

    // Small operands, back-to-back with the previous op.
    mem_m[0][0] = 32'd1; mem_m[0][1] = 32'd2; mem_m[0][2] = 32'd3;
    mem_e[0][9] = 32'h10;
    c0 = cyc;
    issue(0, 3, 0, 9);
    chk("t2_am0", 64'(exp_am[c0 + 1]), 64'h0);
    chk("t2_am2", 64'(exp_am[c0 + 3]), 64'h2);
    chk("t2_w0", 64'(exp_data[c0 + 4]), 64'h10);
    chk("t2_w2", 64'(exp_data[c0 + 6]), 64'h30);
    chk("t2_w3", 64'(exp_data[c0 + 7]), 64'h0);
    chk("t2_idx3", 64'(exp_idx[c0 + 7]), 64'd3);
    wait_cyc(bend[0] + 1);

    // Address wrap.
    for (int i = 0; i < 128; i++) mem_m[0][i] = $urandom;
    mem_e[0][5] = $urandom;
    c0 = cyc;
    issue(0, 4, 7'h7E, 5);
    chk("wrap_am1", 64'(exp_am[c0 + 2]), 64'h7F);
    chk("wrap_am2", 64'(exp_am[c0 + 3]), 64'h00);
    wait_cyc(bend[0] + 1);

    // Start during the done cycle is ignored; the next cycle is accepted.
    issue(0, 3, 10, 1);
    wait_cyc(bend[0]);
    issue(0, 2, 60, 2);
    issue(0, 2, 20, 3);
    wait_cyc(bend[0] + 1);

    // Re-pulsed start during ISSUE.
    c0 = cyc;
    issue(0, 8, 30, 4);
    wait_cyc(c0 + 3);
    issue(0, 5, 90, 7);
    wait_cyc(bend[0] + 1);

    // Reset at cycle 3 of a len=8 op.
    c0 = cyc;
    issue(0, 8, 40, 6);
    wait_cyc(c0 + 3);
    do_reset(1);
    repeat (12) begin
      chk("rst_mid_data", 64'(out_data[0]), 64'(0));
      chk("rst_mid_idx", 64'(out_idx[0]), 64'(0));
      chk("rst_mid_addr_m", 64'(addr_m[0]), 64'(0));
      @(negedge clk);
    end

    // Reset and start together: reset wins.
    reset = 1'b1;
    purge(cyc);
    issue(0, 4, 0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 6, 100, 8);
    wait_cyc(bend[0] + 1);

    // len = 0 right after reset: no reads, addr_m stays 0.
    do_reset(2);
    c0 = cyc;
    issue(0, 0, 7'h55, 3);
    chk("len0_addr_m", 64'(addr_m[0]), 64'(0));
    chk("len0_model_data", 64'(exp_data[c0 + 1]), 64'(0));
    chk("len0_model_done", 64'(exp_done[c0 + 1]), 64'(1));
    wait_cyc(bend[0] + 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 128; i++) mem_m[0][i] = $urandom;
      for (int i = 0; i < 128; i++) mem_e[0][i] = $urandom;
      issue(0, $urandom_range(1, 20), $urandom_range(0, 127), $urandom_range(0, 127));
      wait_cyc(bend[0] + 1);
    end

    // Full 128-word row with the 3-stage multiplier.
    for (int i = 0; i < 128; i++) begin
      mem_m[1][i] = $urandom;
      mem_e[1][i] = $urandom;
    end
    c0 = cyc;
    issue(1, 128, $urandom_range(0, 127), $urandom_range(0, 127));
    chk("big_done_cycle", 64'(bend[1] - c0), 64'd134);
    chk("big_done_idx", 64'(exp_idx[KOFF + c0 + 134]), 64'd128);
    wait_cyc(bend[1] + 1);
    issue(1, 37, $urandom_range(0, 127), $urandom_range(0, 127));
    wait_cyc(bend[1] + 4);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
